// File: rtl/timer_irq_dev.sv
// timer_irq_dev: 32-bit programmable down-counting timer with one interrupt line.
//
// Registers (word select addr_i):
//   0 CTRL   [0] EN, [2:1] MODE (01 = auto-reload, else one-shot), [3] IM,
//            [15:8] PS (only with TIMER_PRESCALE_EN defined), other bits read 0
//   1 PRESET reload value, read/write
//   2 COUNT  current count, read-only
//   3        reserved, reads 0
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   addr_i  word select
//   we_i    write strobe
//   din_i   write data
//   dout_o  read data, combinational from addr_i
//   irq_o   interrupt request: IM & (INT state | pending)
//
// Optional feature macro: TIMER_PRESCALE_EN adds an 8-bit prescaler so each
// decrement takes PS+1 cycles. With it undefined every counting cycle is a tick.

module timer_irq_dev (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  addr_i,
   input  logic        we_i,
   input  logic [31:0] din_i,
   output logic [31:0] dout_o,
   output logic        irq_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_e;

   state_e      state_q;
   logic        en_q;
   logic [1:0]  mode_q;
   logic        im_q;
   logic        pend_q;
   logic [31:0] preset_q;
   logic [31:0] count_q;

   logic        ctrl_we;
   logic        preset_we;
   logic        auto_reload;
   logic        tick;

   assign ctrl_we     = we_i && (addr_i == 2'd0);
   assign preset_we   = we_i && (addr_i == 2'd1);
   assign auto_reload = (mode_q == 2'b01);

`ifdef TIMER_PRESCALE_EN
   logic [7:0] ps_q;
   logic [7:0] psc_q;

   assign tick = (psc_q == ps_q);
`else
   assign tick = 1'b1;
`endif

   // Hardware sequencing first; bus writes are assigned afterwards so a CTRL or
   // PRESET write in the same cycle overrides the INT-state update of EN/pend.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         en_q     <= 1'b0;
         mode_q   <= 2'b00;
         im_q     <= 1'b0;
         pend_q   <= 1'b0;
         preset_q <= '0;
         count_q  <= '0;
`ifdef TIMER_PRESCALE_EN
         ps_q     <= '0;
         psc_q    <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (en_q) state_q <= StLoad;
            end
            StLoad: begin
               count_q <= preset_q;
`ifdef TIMER_PRESCALE_EN
               psc_q   <= '0;
`endif
               state_q <= StCnt;
            end
            StCnt: begin
               if (!en_q) begin
                  state_q <= StIdle;
               end else begin
`ifdef TIMER_PRESCALE_EN
                  psc_q <= tick ? 8'd0 : psc_q + 8'd1;
`endif
                  // Zero is tested before decrementing, so the count never wraps.
                  if (tick) begin
                     if (count_q == 32'd0) state_q <= StInt;
                     else                  count_q <= count_q - 32'd1;
                  end
               end
            end
            StInt: begin
               if (auto_reload) begin
                  state_q <= StLoad;
               end else begin
                  en_q    <= 1'b0;
                  pend_q  <= 1'b1;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         if (ctrl_we) begin
            en_q   <= din_i[0];
            mode_q <= din_i[2:1];
            im_q   <= din_i[3];
`ifdef TIMER_PRESCALE_EN
            ps_q   <= din_i[15:8];
`endif
         end
         if (preset_we)            preset_q <= din_i;
         if (ctrl_we || preset_we) pend_q   <= 1'b0;
      end
   end

   always_comb begin
      dout_o = '0;
      case (addr_i)
         2'd0: begin
            dout_o[0]   = en_q;
            dout_o[2:1] = mode_q;
            dout_o[3]   = im_q;
`ifdef TIMER_PRESCALE_EN
            dout_o[15:8] = ps_q;
`endif
         end
         2'd1:    dout_o = preset_q;
         2'd2:    dout_o = count_q;
         default: dout_o = '0;
      endcase
   end

   assign irq_o = im_q & ((state_q == StInt) | pend_q);

endmodule

// File: tb/tb_timer_irq_dev.sv
// Bench for timer_irq_dev: the driver advances a behavioural timer model on
// every clock edge and queues the dout/irq it expects for the following cycle;
// a monitor pops one entry per falling edge and compares.

module tb_timer_irq_dev;

`ifdef TIMER_PRESCALE_EN
   localparam bit PsEn = 1'b1;
`else
   localparam bit PsEn = 1'b0;
`endif

   // Model phases
   localparam int PIdle = 0;
   localparam int PLoad = 1;
   localparam int PCnt  = 2;
   localparam int PInt  = 3;

   logic        clk;
   logic        rst;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] din;
   logic [31:0] dout;
   logic        irq;

   timer_irq_dev dut (
      .clk    (clk),
      .rst    (rst),
      .addr_i (addr),
      .we_i   (we),
      .din_i  (din),
      .dout_o (dout),
      .irq_o  (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] dout;
      logic        irq;
      logic [1:0]  addr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_fail;
   int   cyc;

   // Inputs currently applied (sampled at the next rising edge)
   logic        cur_rst;
   logic        cur_we;
   logic [1:0]  cur_addr;
   logic [31:0] cur_din;

   // Reference model state
   int          m_phase;
   logic        m_en;
   logic [1:0]  m_mode;
   logic        m_im;
   logic [7:0]  m_ps;
   int          m_psc;
   logic        m_pend;
   logic [31:0] m_preset;
   logic [31:0] m_count;

   task automatic model_reset();
      m_phase  = PIdle;
      m_en     = 1'b0;
      m_mode   = 2'b00;
      m_im     = 1'b0;
      m_ps     = 8'd0;
      m_psc    = 0;
      m_pend   = 1'b0;
      m_preset = 32'd0;
      m_count  = 32'd0;
   endtask

   // One rising edge: timer rules on old values, then the bus write overrides.
   task automatic model_edge();
      int nphase;
      nphase = m_phase;
      if (m_phase == PIdle) begin
         if (m_en) nphase = PLoad;
      end else if (m_phase == PLoad) begin
         m_count = m_preset;
         m_psc   = 0;
         nphase  = PCnt;
      end else if (m_phase == PCnt) begin
         if (!m_en) begin
            nphase = PIdle;
         end else if (m_psc == int'(m_ps)) begin
            m_psc = 0;
            if (m_count == 32'd0) nphase = PInt;
            else                  m_count = m_count - 32'd1;
         end else begin
            m_psc = m_psc + 1;
         end
      end else begin
         if (m_mode == 2'b01) begin
            nphase = PLoad;
         end else begin
            m_en   = 1'b0;
            m_pend = 1'b1;
            nphase = PIdle;
         end
      end
      m_phase = nphase;
      if (cur_we && cur_addr == 2'd0) begin
         m_en   = cur_din[0];
         m_mode = cur_din[2:1];
         m_im   = cur_din[3];
         if (PsEn) m_ps = cur_din[15:8];
         m_pend = 1'b0;
      end
      if (cur_we && cur_addr == 2'd1) begin
         m_preset = cur_din;
         m_pend   = 1'b0;
      end
   endtask

   function automatic logic [31:0] model_dout(input logic [1:0] a);
      logic [31:0] v;
      v = 32'd0;
      if (a == 2'd0) begin
         v[0]    = m_en;
         v[2:1]  = m_mode;
         v[3]    = m_im;
         v[15:8] = m_ps;
      end else if (a == 2'd1) begin
         v = m_preset;
      end else if (a == 2'd2) begin
         v = m_count;
      end
      return v;
   endfunction

   function automatic logic model_irq();
      return m_im && (m_phase == PInt || m_pend);
   endfunction

   task automatic drive(input logic r, input logic w, input logic [1:0] a,
                        input logic [31:0] d);
      exp_t e;
      @(posedge clk);
      if (!cur_rst) model_edge();
      #1;
      rst = r; we = w; addr = a; din = d;
      cur_rst = r; cur_we = w; cur_addr = a; cur_din = d;
      if (r) model_reset();
      cyc++;
      e.dout = model_dout(a);
      e.irq  = model_irq();
      e.addr = a;
      e.cyc  = cyc;
      exp_q.push_back(e);
   endtask

   task automatic rd(input logic [1:0] a);
      drive(1'b0, 1'b0, a, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      drive(1'b0, 1'b1, a, d);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) rd(2'(i % 3 == 0 ? 0 : 2));
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (dout !== e.dout) begin
               n_fail++;
               $display("FAIL dout cyc=%0d addr=%0d: got %h expected %h",
                        e.cyc, e.addr, dout, e.dout);
            end
            n_cmp++;
            if (irq !== e.irq) begin
               n_fail++;
               $display("FAIL irq cyc=%0d: got %b expected %b", e.cyc, irq, e.irq);
            end
         end
      end
   end

   initial begin
      clk = 1'b0; rst = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
      cur_rst = 1'b1; cur_we = 1'b0; cur_addr = 2'd0; cur_din = 32'd0;
      n_cmp = 0; n_fail = 0; cyc = 0;
      model_reset();

      // Reset values
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      drive(1'b1, 1'b0, 2'd1, 32'd0);
      for (int a = 0; a < 4; a++) rd(2'(a));

      // One-shot: PRESET=5, CTRL=EN|IM; irq level until next PRESET write
      wr(2'd1, 32'd5);
      wr(2'd0, 32'h9);
      run(14);
      wr(2'd1, 32'd5);
      run(4);

      // Auto-reload: PRESET=3, CTRL=EN|MODE01|IM
      wr(2'd1, 32'd3);
      wr(2'd0, 32'hB);
      for (int i = 0; i < 20; i++) rd(2'd2);
      wr(2'd0, 32'h0);
      run(3);

      // Masked one-shot, then IM set via CTRL clears pend
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h1);
      run(8);
      wr(2'd0, 32'h8);
      run(3);

      // Disable mid-count near COUNT=7
      wr(2'd1, 32'd20);
      wr(2'd0, 32'h9);
      for (int i = 0; i < 14; i++) rd(2'd2);
      wr(2'd0, 32'h8);
      for (int i = 0; i < 5; i++) rd(2'd2);

      // CTRL write colliding with the one-shot INT cycle, plus ignored COUNT write
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h9);
      for (int i = 0; i < 5; i++) rd(2'd2);
      wr(2'd0, 32'h9);
      rd(2'd0);
      wr(2'd2, 32'hDEAD_BEEF);
      for (int i = 0; i < 6; i++) rd(2'd2);

      // Prescaler PS=3 (PS field ignored when the feature is absent)
      wr(2'd0, 32'h0);
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h30B);
      for (int i = 0; i < 30; i++) rd(2'(i % 4 == 0 ? 0 : 2));

      // Reset mid-count
      wr(2'd0, 32'h0);
      wr(2'd1, 32'd9);
      wr(2'd0, 32'h9);
      run(5);
      drive(1'b1, 1'b0, 2'd2, 32'd0);
      drive(1'b1, 1'b0, 2'd0, 32'd0);
      for (int a = 0; a < 4; a++) rd(2'(a));

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         logic [1:0]  a;
         logic [31:0] d;
         a = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) begin
            drive(1'b1, 1'b0, a, 32'd0);
         end else if ($urandom_range(0, 9) == 0) begin
            if (a == 2'd0)      d = ($urandom_range(0, 3) << 8) | $urandom_range(0, 15);
            else if (a == 2'd1) d = 32'($urandom_range(0, 12));
            else                d = $urandom;
            wr(a, d);
         end else begin
            rd(a);
         end
      end
      rd(2'd0);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_irq_dev.md
# timer_irq_dev

Programmable 32-bit down-counting timer that sits on the CPU's peripheral bus and drives one hardware interrupt line into the coprocessor-0 interrupt logic (HWInt[2]). Software programs it through three word registers (CTRL, PRESET, COUNT). It raises `irq` either as a level held until software acknowledges it (one-shot mode) or as a one-cycle pulse per period (auto-reload mode).

## Interface
Parameters:
- None.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- addr  in  2  word select (bus address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
- we  in  1  write strobe; sampled at the rising edge.
- din  in  32  write data.
- dout  out  32  read data, combinational from `addr`.
- irq  out  1  interrupt request to CP0 HWInt[2].

## Operation
- CTRL fields:
  - [0] EN: count enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10/11 behave as 00.
  - [3] IM: interrupt mask, 1 = allow.
  - All other bits read 0.
- PRESET: 32-bit reload value, read/write.
- COUNT: read-only; writes are ignored.
- Reads of addr 3 return 0.
- Pending flag `pend` (internal, one-shot mode only):
  - set when leaving INT in one-shot mode;
  - cleared by any bus write to CTRL or PRESET.
- `irq = IM & ((state==INT) | pend)`.
- State machine:
  - IDLE: if EN → LOAD; else stay.
  - LOAD: COUNT←PRESET; → CNT.
  - CNT: if EN==0 → IDLE (COUNT holds); else if COUNT==0 → INT; else COUNT←COUNT−1.
  - INT, one-shot: EN←0, pend←1, → IDLE.
  - INT, auto-reload: → LOAD (pend untouched).
- Bus write to CTRL in the same cycle as the INT-state hardware update: the written CTRL value wins, and `pend` is cleared.
- PRESET written mid-count takes effect at the next LOAD only.
- COUNT arithmetic is unsigned 32-bit; COUNT==0 is detected before decrement, so it never wraps.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0, irq=0; dout = selected register (0 after reset).
- Write edge E0 sets EN with PRESET=N:
  - E1 LOAD;
  - E2 COUNT=N;
  - COUNT=0 at E(N+2);
  - INT at E(N+3); `irq` rises after E(N+3).
- Auto-reload: `irq` high for exactly one cycle, period N+3 cycles.
- One-shot: `irq` stays high from E(N+3) until the edge of the next CTRL/PRESET write.
- Clearing IM masks `irq` combinationally but does not clear `pend`.
- `rst` asserted mid-count returns all state to reset values immediately.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - CTRL[15:8] = PS (8-bit, read/write).
  - An internal prescale counter is zeroed in LOAD and increments in CNT; a tick occurs when it equals PS, and the counter then wraps to 0.
  - CNT transitions (decrement, → INT) occur only on tick cycles, so time per decrement is PS+1 cycles.
  - EN==0 exit from CNT is not gated by tick.
- Undefined: CTRL[15:8] read 0, writes ignored, every CNT cycle is a tick.
- With PS=0 both builds are cycle-identical.

## Test plan
- Reset: assert rst mid-operation → CTRL/PRESET/COUNT read 0, irq=0, state IDLE.
- One-shot: PRESET=5, CTRL=0b1001 → irq rises 8 cycles after write edge, stays high; CTRL reads EN=0; write PRESET=5 → irq falls next edge.
- Auto-reload: PRESET=3, CTRL=0b1011 → one-cycle irq pulses every 6 cycles, COUNT sequence 3,2,1,0 repeating.
- Mask and disable: one-shot with IM=0 → irq never rises; then write IM=1 via CTRL (clears pend) → irq stays 0. Separately, clear EN mid-count at COUNT=7 → COUNT holds 7, no irq.
- Collision: CTRL write of 0b1001 landing on the one-shot INT cycle → EN stays 1, pend=0, new LOAD follows; COUNT write ignored.
- `TIMER_PRESCALE_EN`: PS=3, PRESET=2, auto-reload → COUNT decrements every 4 cycles; CTRL readback includes PS=3.
